// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC z-path front end.
// Angles are Q3.61 at full precision; narrower datapaths take the top
// BIT_WIDTH bits (truncation), matching the slicing used by the core's LUT.
package cordic_pkg;

  // pi and pi/2 in Q3.61
  localparam logic [63:0] CORDIC_PI      = 64'h6487_ED51_10B4_611A;
  localparam logic [63:0] CORDIC_HALF_PI = 64'h3243_F6A8_885A_308D;

  // Largest iteration count the core supports
  localparam int MAX_ITERATIONS = 64;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_angle_frontend_angle_fold.sv
// angle_fold: combinational clamp to [-pi, pi] followed by a fold into the
// core's convergence range [-pi/2, pi/2]. A folded angle means the core's
// x/y result must be negated downstream.
module angle_fold
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 64
) (
  input  logic [BIT_WIDTH-1:0] angle_in,
  output logic [BIT_WIDTH-1:0] z_folded,
  output logic                 negate
);

  // One guard bit so that a +/- pi adjustment can never wrap
  localparam logic signed [BIT_WIDTH:0] PI_EXT =
    {1'b0, CORDIC_PI[63 -: BIT_WIDTH]};
  localparam logic signed [BIT_WIDTH:0] HALF_PI_EXT =
    {1'b0, CORDIC_HALF_PI[63 -: BIT_WIDTH]};

  logic signed [BIT_WIDTH:0] a_ext;
  logic signed [BIT_WIDTH:0] clamped;
  logic signed [BIT_WIDTH:0] folded;
  logic                      fold_unused_msb;

  // Clamp then fold; strict comparisons leave exactly +/- pi/2 untouched
  always_comb begin
    a_ext = $signed({angle_in[BIT_WIDTH-1], angle_in});

    if (a_ext > PI_EXT) begin
      clamped = PI_EXT;
    end else if (a_ext < -PI_EXT) begin
      clamped = -PI_EXT;
    end else begin
      clamped = a_ext;
    end

    if (clamped > HALF_PI_EXT) begin
      folded = clamped - PI_EXT;
      negate = 1'b1;
    end else if (clamped < -HALF_PI_EXT) begin
      folded = clamped + PI_EXT;
      negate = 1'b1;
    end else begin
      folded = clamped;
      negate = 1'b0;
    end
  end

  // The folded result lies within [-pi/2, pi/2], so the guard bit is redundant
  assign z_folded        = folded[BIT_WIDTH-1:0];
  assign fold_unused_msb = folded[BIT_WIDTH];

endmodule

// File: rtl/cordic_angle_frontend.sv
// cordic_angle_frontend: accepts one angle per transaction, folds it into the
// CORDIC convergence range, strobes the core, counts its iterations and hands
// completion, negate flag and residual angle to the x/y post-processing stage.
// Optional convergence check: define CORDIC_CONV_CHECK_EN to flag residuals
// whose magnitude exceeds CONV_TOL; otherwise conv_err is constant 0.
module cordic_angle_frontend
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 64,
  parameter int ITERATIONS = 64,
  parameter int CONV_TOL   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] angle_in,
  output logic [BIT_WIDTH-1:0] z_initial,
  output logic                 core_start,
  input  logic [BIT_WIDTH-1:0] z_residual,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_negate,
  output logic [BIT_WIDTH-1:0] out_residual,
  output logic                 conv_err
);

  // Counter needs to reach ITERATIONS-1; one extra bit keeps saturation clear of it
  localparam int               CNT_W     = $clog2(ITERATIONS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BIT_WIDTH-1:0]   z_initial_q, z_initial_d;
  logic                   out_negate_q, out_negate_d;
  logic                   core_start_q, core_start_d;
  logic                   out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0]   out_residual_q, out_residual_d;

  logic [BIT_WIDTH-1:0]   fold_z;
  logic                   fold_negate;
  logic                   conv_hit;

  angle_fold #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_angle_fold (
    .angle_in (angle_in),
    .z_folded (fold_z),
    .negate   (fold_negate)
  );

`ifdef CORDIC_CONV_CHECK_EN
  logic signed [BIT_WIDTH:0] resid_ext;
  logic        [BIT_WIDTH:0] resid_abs;
  logic                      conv_err_q, conv_err_d;

  // Magnitude at one extra bit so the most negative residual stays positive
  always_comb begin
    resid_ext = $signed({z_residual[BIT_WIDTH-1], z_residual});
    resid_abs = resid_ext[BIT_WIDTH] ? (-resid_ext) : resid_ext;
    conv_hit  = (resid_abs > (BIT_WIDTH+1)'(CONV_TOL));
  end

  assign conv_err = conv_err_q;
`else
  // Tolerance is only meaningful with the convergence check built in
  localparam int conv_tol_unused = CONV_TOL;

  assign conv_hit = 1'b0;
  assign conv_err = 1'b0;
`endif

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    z_initial_d    = z_initial_q;
    out_negate_d   = out_negate_q;
    core_start_d   = 1'b0;
    out_valid_d    = out_valid_q;
    out_residual_d = out_residual_q;
`ifdef CORDIC_CONV_CHECK_EN
    conv_err_d     = conv_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d      = ST_LOAD;
          z_initial_d  = fold_z;
          out_negate_d = fold_negate;
          core_start_d = 1'b1;
        end
      end

      ST_LOAD: begin
        state_d = ST_RUN;
        count_d = '0;
      end

      ST_RUN: begin
        if (count_q != CNT_SAT) begin
          count_d = count_q + 1'b1;
        end
        if (count_q == CNT_LAST) begin
          state_d        = ST_DONE;
          out_valid_d    = 1'b1;
          out_residual_d = z_residual;
`ifdef CORDIC_CONV_CHECK_EN
          conv_err_d     = conv_hit;
`endif
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      z_initial_q    <= '0;
      out_negate_q   <= 1'b0;
      core_start_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      out_residual_q <= '0;
`ifdef CORDIC_CONV_CHECK_EN
      conv_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      z_initial_q    <= z_initial_d;
      out_negate_q   <= out_negate_d;
      core_start_q   <= core_start_d;
      out_valid_q    <= out_valid_d;
      out_residual_q <= out_residual_d;
`ifdef CORDIC_CONV_CHECK_EN
      conv_err_q     <= conv_err_d;
`endif
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign z_initial    = z_initial_q;
  assign out_negate   = out_negate_q;
  assign core_start   = core_start_q;
  assign out_valid    = out_valid_q;
  assign out_residual = out_residual_q;

endmodule

// File: doc/cordic_angle_frontend.md
# cordic_angle_frontend

Input-side sequencer for the iterative CORDIC z-path core. It accepts one angle per transaction over a valid/ready handshake. It folds the angle into the core's convergence range [-π/2, π/2] and drives the core's initial angle together with a one-cycle start strobe. It then counts the core's iterations and presents completion, a result-negate flag and the captured residual angle to the downstream x/y post-processing stage.

## Interface
- BIT_WIDTH, 64: angle width; signed two's complement, Q3.(BIT_WIDTH-3).
- ITERATIONS, 64: core iterations per transaction; range 1..64.
- CONV_TOL, 16: maximum allowed |residual| in LSBs; used only with the convergence check.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  angle_in is valid.
- in_ready  output  1  block can accept an angle.
- angle_in  input  BIT_WIDTH  requested angle in radians.
- z_initial  output  BIT_WIDTH  folded angle to the core's initial-angle input.
- core_start  output  1  one-cycle strobe; the core loads z_initial.
- z_residual  input  BIT_WIDTH  core's current z output.
- out_valid  output  1  transaction complete.
- out_ready  input  1  downstream accepts the completion.
- out_negate  output  1  downstream must negate x and y.
- out_residual  output  BIT_WIDTH  z_residual captured at completion.
- conv_err  output  1  |residual| exceeded CONV_TOL.

## Operation
- States:
  - IDLE: in_ready=1.
  - LOAD: core_start=1.
  - RUN: iteration counter active.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→LOAD on in_valid&in_ready.
  - LOAD→RUN unconditionally.
  - RUN→DONE when count==ITERATIONS-1.
  - DONE→IDLE on out_valid&out_ready.
- Clamp, on capture: angle_in > PI → PI; angle_in < -PI → -PI.
- Fold, applied to the clamped value a:
  - a > HALF_PI: z_initial = a-PI, negate=1.
  - a < -HALF_PI: z_initial = a+PI, negate=1.
  - Otherwise: z_initial = a, negate=0.
  - Comparisons are strict, so exactly ±HALF_PI is not folded.
  - Fold arithmetic uses a BIT_WIDTH+1 internal width; the result always fits in BIT_WIDTH.
- PI and HALF_PI are the top BIT_WIDTH bits of their 64-bit Q3.61 package constants (truncation). The same slicing is used for the core's LUT.
- Counter: width $clog2(ITERATIONS)+1. Cleared in LOAD, increments each RUN cycle, saturates.
- z_initial and out_negate are registered and held constant from LOAD until the next capture.
- out_residual is captured on the RUN→DONE edge and held through DONE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Capture edge T (IDLE, in_valid=1):
  - T+1: LOAD. z_initial is valid and core_start=1 for exactly one cycle.
  - T+2 to T+1+ITERATIONS: RUN.
  - T+2+ITERATIONS: out_valid rises. Latency is ITERATIONS+2 cycles.
- out_valid, out_negate, out_residual and conv_err are held stable until the cycle after out_ready is sampled high.
- The earliest next capture is one cycle after the completion handshake, since in_ready=1 only in IDLE. No overlap between transactions.
- A completion stall of any length is permitted. The core keeps iterating, but the captured residual is not updated.
- Reset: asynchronous to IDLE.
  - Outputs reset to z_initial=0, core_start=0, out_valid=0, out_negate=0, out_residual=0, conv_err=0, counter=0.
  - in_ready decodes from IDLE.
  - No capture occurs while rst=0.
- Reset mid-RUN or mid-DONE aborts the transaction; no completion is issued.

## Configuration
- CORDIC_CONV_CHECK_EN defined: on the RUN→DONE edge, conv_err <= (|z_residual| > CONV_TOL). The absolute value is computed at BIT_WIDTH+1 bits, so the most negative input does not overflow.
- Not defined: conv_err is tied to 0; no comparator or CONV_TOL logic is present.

## Structure
- Shared package cordic_pkg:
  - 64-bit Q3.61 constants CORDIC_PI and CORDIC_HALF_PI.
  - State enum type.
  - MAX_ITERATIONS = 64.
- One sub-module: angle_fold (combinational clamp and fold; outputs folded angle and negate).

## Test plan
BIT_WIDTH=16, ITERATIONS=4, PI=0x6487, HALF_PI=0x3243.
- angle_in=0x1000 → z_initial=0x1000, out_negate=0; core_start at T+1; out_valid at T+6.
- angle_in=0x4000 → z_initial=0xDB79, out_negate=1. angle_in=0xC000 → z_initial=0x2487, out_negate=1.
- angle_in=0x3243 → z_initial=0x3243, out_negate=0. angle_in=0x3244 → z_initial=0xCDBD, out_negate=1.
- angle_in=0x7000 (clamped) → z_initial=0x0000, out_negate=1.
- out_ready held 0 for 10 cycles → out_valid and outputs stable, in_ready=0. Then out_ready=1 → IDLE the next cycle, and a back-to-back second angle is captured.
- rst pulsed low during RUN → all outputs 0 immediately, no out_valid. With CORDIC_CONV_CHECK_EN defined, z_residual=0x0020 at completion → conv_err=1; z_residual=0xFFF8 → conv_err=0.
